// File: rtl/frame_if.sv
// Output-side bus of frame_tx: one-shot control word plus a valid/ready pixel stream.
// The master drives both qualifiers; the slave supplies backpressure on the pixel stream only.
interface frame_if;
    logic [35:0] control_out_data;
    logic        control_out_valid;
    logic [23:0] video_out_data;
    logic        video_out_valid;
    logic        video_out_ready;

    modport master (
        output control_out_data,
        output control_out_valid,
        output video_out_data,
        output video_out_valid,
        input  video_out_ready
    );

    modport slave (
        input  control_out_data,
        input  control_out_valid,
        input  video_out_data,
        input  video_out_valid,
        output video_out_ready
    );
endinterface

// File: rtl/frame_tx.sv
// Test-pattern frame transmitter: on start emits one control word and then a raster of
// YCbCr pixels, under valid/ready backpressure.
//
// state  | meaning
// IDLE   | waiting for start; config register writable
// CTRL   | control word presented for one cycle
// ACTIVE | pixels presented, scan advances on each transfer
// DONE   | one-cycle frame_done pulse, frame counter advances
module frame_tx #(
    parameter logic [15:0] DEFAULT_WIDTH  = 16'd640,
    parameter logic [15:0] DEFAULT_HEIGHT = 16'd480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic        cfg_valid,
    input  logic [1:0]  pattern_sel,
    input  logic        start,
    frame_if.master     bus,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, CTRL, ACTIVE, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] cfg_w, cfg_w_next, cfg_h, cfg_h_next;
    logic [15:0] sh_w, sh_w_next, sh_h, sh_h_next;
    logic [1:0]  sh_pat, sh_pat_next;
    logic [15:0] x_cnt, x_next, y_cnt, y_next;
    logic [7:0]  frame_cnt, frame_cnt_next;
    logic [35:0] ctrl_data, ctrl_data_next;
    logic        ctrl_valid, ctrl_valid_next;
    logic [23:0] vid_data, vid_data_next;
    logic        vid_valid, vid_valid_next;
    logic        busy_r, busy_next;
    logic        done_r, done_next;
    logic [15:0] eff_w, eff_h;
    logic        xfer;

    function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [15:0] x,
                                          input logic [15:0] y, input logic [7:0] fc);
        logic [23:0] p;
        case (pat)
            2'd0:    p = {x[7:0], 8'h80, 8'h80};
            2'd1:    p = {y[7:0], 8'h80, 8'h80};
            2'd2:    p = {((x[3] ^ y[3]) ? 8'hEB : 8'h10), 8'h80, 8'h80};
            default: p = {fc, x[7:0], y[7:0]};
        endcase
        return p;
    endfunction

    // Outputs are all decoded into registers here, so ready only reaches flops.
    always_comb begin
        state_next      = state;
        cfg_w_next      = cfg_w;
        cfg_h_next      = cfg_h;
        sh_w_next       = sh_w;
        sh_h_next       = sh_h;
        sh_pat_next     = sh_pat;
        x_next          = x_cnt;
        y_next          = y_cnt;
        frame_cnt_next  = frame_cnt;
        ctrl_data_next  = 36'h0;
        ctrl_valid_next = 1'b0;
        vid_data_next   = vid_data;
        vid_valid_next  = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        eff_w           = cfg_valid ? cfg_width  : cfg_w;
        eff_h           = cfg_valid ? cfg_height : cfg_h;
        xfer            = vid_valid & bus.video_out_ready;

        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_w_next = cfg_width;
                    cfg_h_next = cfg_height;
                end
                if (start && eff_w != 16'd0 && eff_h != 16'd0) begin
                    state_next      = CTRL;
                    sh_w_next       = eff_w;
                    sh_h_next       = eff_h;
                    sh_pat_next     = pattern_sel;
                    ctrl_valid_next = 1'b1;
                    ctrl_data_next  = {eff_w, eff_h, 4'h0};
                    busy_next       = 1'b1;
                end
            end
            CTRL: begin
                state_next     = ACTIVE;
                x_next         = 16'd0;
                y_next         = 16'd0;
                vid_valid_next = 1'b1;
                vid_data_next  = pixel(sh_pat, 16'd0, 16'd0, frame_cnt);
                busy_next      = 1'b1;
            end
            ACTIVE: begin
                busy_next      = 1'b1;
                vid_valid_next = 1'b1;
                if (xfer) begin
                    if (x_cnt == sh_w - 16'd1) begin
                        x_next = 16'd0;
                        if (y_cnt == sh_h - 16'd1) begin
                            y_next = 16'd0;
                        end else begin
                            y_next = y_cnt + 16'd1;
                        end
                    end else begin
                        x_next = x_cnt + 16'd1;
                    end
                    if (x_cnt == sh_w - 16'd1 && y_cnt == sh_h - 16'd1) begin
                        state_next     = DONE;
                        vid_valid_next = 1'b0;
                        vid_data_next  = 24'h0;
                        done_next      = 1'b1;
                    end else begin
                        vid_data_next = pixel(sh_pat, x_next, y_next, frame_cnt);
                    end
                end
            end
            DONE: begin
                state_next     = IDLE;
                frame_cnt_next = frame_cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cfg_w      <= DEFAULT_WIDTH;
            cfg_h      <= DEFAULT_HEIGHT;
            sh_w       <= 16'd0;
            sh_h       <= 16'd0;
            sh_pat     <= 2'd0;
            x_cnt      <= 16'd0;
            y_cnt      <= 16'd0;
            frame_cnt  <= 8'd0;
            ctrl_data  <= 36'h0;
            ctrl_valid <= 1'b0;
            vid_data   <= 24'h0;
            vid_valid  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_next;
            cfg_w      <= cfg_w_next;
            cfg_h      <= cfg_h_next;
            sh_w       <= sh_w_next;
            sh_h       <= sh_h_next;
            sh_pat     <= sh_pat_next;
            x_cnt      <= x_next;
            y_cnt      <= y_next;
            frame_cnt  <= frame_cnt_next;
            ctrl_data  <= ctrl_data_next;
            ctrl_valid <= ctrl_valid_next;
            vid_data   <= vid_data_next;
            vid_valid  <= vid_valid_next;
            busy_r     <= busy_next;
            done_r     <= done_next;
        end
    end

    assign bus.control_out_data  = ctrl_data;
    assign bus.control_out_valid = ctrl_valid;
    assign bus.video_out_data    = vid_data;
    assign bus.video_out_valid   = vid_valid;
    assign busy                  = busy_r;
    assign frame_done            = done_r;

endmodule

// File: tb/tb_frame_tx.sv
// Directed and randomized bench for frame_tx, checked against a frame-level reference model
// (expected pixel sequence derived from scan order and the pattern rules).
module tb_frame_tx;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic        cfg_valid;
    logic [1:0]  pattern_sel;
    logic        start;
    logic        busy;
    logic        frame_done;

    frame_if fif();

    frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .cfg_valid   (cfg_valid),
        .pattern_sel (pattern_sel),
        .start       (start),
        .bus         (fif),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int m_cfg_w, m_cfg_h, m_fc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int pat, input int x, input int y, input int fc);
        logic [7:0] xb, yb, fb, lum;
        xb = 8'(x % 256);
        yb = 8'(y % 256);
        fb = 8'(fc % 256);
        lum = (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hEB : 8'h10;
        case (pat)
            0:       return {xb, 8'h80, 8'h80};
            1:       return {yb, 8'h80, 8'h80};
            2:       return {lum, 8'h80, 8'h80};
            default: return {fb, xb, yb};
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cdata"},  fif.control_out_data, 64'h0);
        chk({tag, "_cvalid"}, fif.control_out_valid, 64'h0);
        chk({tag, "_vdata"},  fif.video_out_data, 64'h0);
        chk({tag, "_vvalid"}, fif.video_out_valid, 64'h0);
        chk({tag, "_busy"},   busy, 64'h0);
        chk({tag, "_done"},   frame_done, 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        cfg_valid = 1'b0;
        tick();
        chk_all_zero("rst");
        rst = 1'b0;
        m_cfg_w = 640;
        m_cfg_h = 480;
        m_fc = 0;
        tick();
        chk("post_rst_busy", busy, 64'h0);
    endtask

    // rmode: 0 ready tied high, 1 ready toggles 1,0,1,..., 2 random ready plus stray starts.
    task automatic run_frame(input int w, input int h, input int pat, input bit load,
                             input int rmode, input bit inject, input int abort_after);
        int fw, fh, idx, total, cyc, budget;
        bit r, tog;
        logic [35:0] exp_c;
        pattern_sel = 2'(pat);
        start = 1'b1;
        if (load) begin
            cfg_width = 16'(w);
            cfg_height = 16'(h);
            cfg_valid = 1'b1;
            m_cfg_w = w;
            m_cfg_h = h;
        end
        fw = m_cfg_w;
        fh = m_cfg_h;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        pattern_sel = 2'($urandom);
        exp_c = {fw[15:0], fh[15:0], 4'h0};
        chk("ctrl_valid", fif.control_out_valid, 64'h1);
        chk("ctrl_data", fif.control_out_data, 64'(exp_c));
        chk("ctrl_busy", busy, 64'h1);
        chk("ctrl_vvalid", fif.video_out_valid, 64'h0);
        tick();
        chk("ctrl_one_cycle", fif.control_out_valid, 64'h0);
        idx = 0;
        total = fw * fh;
        cyc = 0;
        tog = 1'b1;
        budget = 20 * total + 20;
        while (idx < total && cyc < budget) begin
            if (abort_after >= 0 && idx == abort_after) begin
                rst = 1'b1;
                tick();
                chk_all_zero("abort");
                rst = 1'b0;
                m_cfg_w = 640;
                m_cfg_h = 480;
                m_fc = 0;
                tick();
                chk("abort_idle_busy", busy, 64'h0);
                chk("abort_no_done", frame_done, 64'h0);
                return;
            end
            chk("pix_valid", fif.video_out_valid, 64'h1);
            chk("pix_data", fif.video_out_data, 64'(ref_pix(pat, idx % fw, idx / fw, m_fc)));
            chk("pix_no_done", frame_done, 64'h0);
            case (rmode)
                0:       r = 1'b1;
                1:       r = tog;
                default: r = 1'($urandom);
            endcase
            tog = ~tog;
            if (inject && cyc == 0) begin
                cfg_width = 16'd8;
                cfg_height = 16'd8;
                cfg_valid = 1'b1;
            end
            if (rmode == 2) start = 1'($urandom);
            fif.video_out_ready = r;
            tick();
            cfg_valid = 1'b0;
            start = 1'b0;
            if (r) idx++;
            cyc++;
        end
        chk("xfer_count_in_budget", 64'(idx), 64'(total));
        fif.video_out_ready = 1'($urandom);
        chk("done_pulse", frame_done, 64'h1);
        chk("done_vvalid", fif.video_out_valid, 64'h0);
        chk("done_busy", busy, 64'h1);
        m_fc = (m_fc + 1) % 256;
        tick();
        chk("idle_busy", busy, 64'h0);
        chk("idle_done", frame_done, 64'h0);
        chk("idle_vvalid", fif.video_out_valid, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_width = 16'd0;
        cfg_height = 16'd0;
        cfg_valid = 1'b0;
        pattern_sel = 2'd0;
        start = 1'b0;
        fif.video_out_ready = 1'b0;
        m_cfg_w = 640;
        m_cfg_h = 480;
        m_fc = 0;
        tick();
        do_reset();

        // default config reported in control word, then abandoned by reset
        run_frame(0, 0, 0, 1'b0, 0, 1'b0, 0);

        run_frame(4, 2, 0, 1'b1, 0, 1'b0, -1);
        run_frame(3, 1, 0, 1'b1, 1, 1'b0, -1);

        // zero width: start must be ignored
        cfg_width = 16'd0;
        cfg_height = 16'd5;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        m_cfg_w = 0;
        m_cfg_h = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("zero_busy", busy, 64'h0);
            chk("zero_cvalid", fif.control_out_valid, 64'h0);
            chk("zero_done", frame_done, 64'h0);
            tick();
        end

        do_reset();
        run_frame(2, 2, 3, 1'b1, 0, 1'b0, -1);
        run_frame(2, 2, 3, 1'b0, 2, 1'b0, -1);

        // cfg write during ACTIVE ignored for this and the next frame
        run_frame(2, 2, 0, 1'b1, 0, 1'b1, -1);
        run_frame(2, 2, 1, 1'b0, 1, 1'b0, -1);

        run_frame(4, 4, 0, 1'b1, 0, 1'b0, 5);
        run_frame(4, 4, 2, 1'b1, 2, 1'b0, -1);

        run_frame(16, 2, 2, 1'b1, 2, 1'b0, -1);
        run_frame(1, 1, 3, 1'b1, 0, 1'b0, -1);
        run_frame(2, 3, 1, 1'b1, 2, 1'b0, -1);
        for (int k = 0; k < 6; k++) begin
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 3)), 1'b1, 2, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
